// File: rtl/memory_writeback.sv
// memory_writeback: memory-access and writeback stage of a 5-stage MIPS pipeline.
// Non-memory results pass to the register-file write port in one cycle. Loads
// and stores go through a request/acknowledge data-memory port and stall the
// upstream stage until the memory acknowledges.
// Optional build macro: MISALIGN_TRAP_EN (blocks memory ops whose address is not
// word aligned and raises a sticky misalign_err flag).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accepting XM_* every cycle; non-memory ops retire directly
// ACCESS  | memory request outstanding; upstream stalled until dm_ack
module memory_writeback #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              XM_valid,
    input  logic              XM_MemtoReg,
    input  logic              XM_RegWrite,
    input  logic              XM_MemRead,
    input  logic              XM_MemWrite,
    input  logic [31:0]       XM_ALUout,
    input  logic [31:0]       XM_MD,
    input  logic [4:0]        XM_RD,
    output logic              stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic              MW_MemtoReg,
    output logic              MW_RegWrite,
    output logic [4:0]        MW_RD,
    output logic [31:0]       MDR,
    output logic [31:0]       MW_ALUout,
    output logic              misalign_err
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic               r_dm_req;
    logic               r_dm_we;
    logic [ADDR_W-1:0]  r_dm_addr;
    logic [31:0]        r_dm_wdata;

    logic [4:0]         r_sv_rd;
    logic               r_sv_regwrite;
    logic [31:0]        r_sv_aluout;

    logic               r_mw_memtoreg;
    logic               r_mw_regwrite;
    logic [4:0]         r_mw_rd;
    logic [31:0]        r_mdr;
    logic [31:0]        r_mw_aluout;

    logic               w_mem_op;
    logic               w_misalign;
    logic               w_issue;
    logic               w_ack;

    // Loads always write back memory data, so the incoming MemtoReg bit carries
    // no extra information for this stage.
    logic               w_unused_memtoreg;
    assign w_unused_memtoreg = XM_MemtoReg;

    assign w_mem_op = XM_valid & (XM_MemRead | XM_MemWrite);

`ifdef MISALIGN_TRAP_EN
    logic r_misalign_err;

    assign w_misalign = (XM_ALUout[1:0] != 2'b00);

    // Sticky flag: set by any blocked misaligned memory op, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_misalign_err <= 1'b0;
        end else if (r_state == S_IDLE && w_mem_op && w_misalign) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign misalign_err = r_misalign_err;
`else
    assign w_misalign   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign w_issue = w_mem_op & ~w_misalign;
    // An acknowledge only counts while a request is actually outstanding.
    assign w_ack   = r_dm_req & dm_ack;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_ack) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Memory port, saved instruction fields and writeback registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dm_req      <= 1'b0;
            r_dm_we       <= 1'b0;
            r_dm_addr     <= '0;
            r_dm_wdata    <= '0;
            r_sv_rd       <= '0;
            r_sv_regwrite <= 1'b0;
            r_sv_aluout   <= '0;
            r_mw_memtoreg <= 1'b0;
            r_mw_regwrite <= 1'b0;
            r_mw_rd       <= '0;
            r_mdr         <= '0;
            r_mw_aluout   <= '0;
        end else begin
            // Write-enable is a one-cycle pulse per retired instruction.
            r_mw_regwrite <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_dm_req      <= 1'b1;
                        // Both MemRead and MemWrite set resolves to a store.
                        r_dm_we       <= XM_MemWrite;
                        r_dm_addr     <= XM_ALUout[ADDR_W-1:0];
                        r_dm_wdata    <= XM_MD;
                        r_sv_rd       <= XM_RD;
                        r_sv_regwrite <= XM_RegWrite;
                        r_sv_aluout   <= XM_ALUout;
                    end else if (XM_valid && !w_mem_op) begin
                        r_mw_regwrite <= XM_RegWrite;
                        r_mw_memtoreg <= 1'b0;
                        r_mw_rd       <= XM_RD;
                        r_mw_aluout   <= XM_ALUout;
                    end
                end
                S_ACCESS: begin
                    if (w_ack) begin
                        r_dm_req    <= 1'b0;
                        r_mw_rd     <= r_sv_rd;
                        r_mw_aluout <= r_sv_aluout;
                        if (!r_dm_we) begin
                            r_mdr         <= dm_rdata;
                            r_mw_memtoreg <= 1'b1;
                            r_mw_regwrite <= r_sv_regwrite;
                        end else begin
                            r_mw_memtoreg <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_dm_req <= 1'b0;
                end
            endcase
        end
    end

    assign stall       = (r_state == S_ACCESS);
    assign dm_req      = r_dm_req;
    assign dm_we       = r_dm_we;
    assign dm_addr     = r_dm_addr;
    assign dm_wdata    = r_dm_wdata;
    assign MW_MemtoReg = r_mw_memtoreg;
    assign MW_RegWrite = r_mw_regwrite;
    assign MW_RD       = r_mw_rd;
    assign MDR         = r_mdr;
    assign MW_ALUout   = r_mw_aluout;

endmodule

// File: tb/tb_memory_writeback.sv
// Self-checking bench for memory_writeback: scoreboard queues for expected
// writebacks and expected memory requests, a memory responder and a writeback
// monitor, driven by directed instruction vectors.
module tb_memory_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        XM_valid, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
    logic [31:0] XM_ALUout, XM_MD;
    logic [4:0]  XM_RD;
    logic        stall, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        MW_MemtoReg, MW_RegWrite;
    logic [4:0]  MW_RD;
    logic [31:0] MDR, MW_ALUout;
    logic        misalign_err;

    always #5 clk = ~clk;

    memory_writeback #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .XM_valid(XM_valid), .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
        .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
        .XM_ALUout(XM_ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD),
        .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .MW_MemtoReg(MW_MemtoReg), .MW_RegWrite(MW_RegWrite), .MW_RD(MW_RD),
        .MDR(MDR), .MW_ALUout(MW_ALUout), .misalign_err(misalign_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        m2r;
        logic [31:0] mdr;
        logic        chk_mdr;
        int          gap;      // required cycles since previous writeback, -1 = any
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    wb_t         wb_q[$];
    req_t        req_q[$];
    wb_t         mon_e;
    req_t        mem_e;
    req_t        mem_cap;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          stall_total = 0;
    int          last_wb_cycle = -100;
    int          mem_cnt = 0;
    int          mem_wait = 0;
    logic [31:0] mem_rdata = 32'h0;
    logic        force_ack = 1'b0;
    int          s0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic wb_t mk_wb(input logic [4:0] rd, input logic [31:0] alu, input logic m2r,
                                  input logic [31:0] mdr, input logic chk_mdr, input int gap);
        wb_t w;
        w.rd = rd; w.alu = alu; w.m2r = m2r; w.mdr = mdr; w.chk_mdr = chk_mdr; w.gap = gap;
        return w;
    endfunction

    function automatic req_t mk_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    always @(posedge clk) cycle++;

    // Writeback monitor: every MW_RegWrite pulse must match the next queued retirement.
    initial begin
        forever begin
            @(negedge clk);
            if (stall) stall_total++;
            if (rst && MW_RegWrite) begin
                if (wb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_writeback: got rd=%0d alu=0x%08h expected none", MW_RD, MW_ALUout);
                end else begin
                    mon_e = wb_q.pop_front();
                    check("wb_rd", {27'b0, MW_RD}, {27'b0, mon_e.rd});
                    check("wb_aluout", MW_ALUout, mon_e.alu);
                    check("wb_memtoreg", {31'b0, MW_MemtoReg}, {31'b0, mon_e.m2r});
                    if (mon_e.chk_mdr) check("wb_mdr", MDR, mon_e.mdr);
                    if (mon_e.gap >= 0) check("wb_gap", cycle - last_wb_cycle, mon_e.gap);
                end
                last_wb_cycle = cycle;
            end
        end
    end

    // Memory responder: checks each new request against the queue, checks the
    // request stays stable while waiting, and acknowledges after mem_wait cycles.
    initial begin
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        forever begin
            @(negedge clk);
            dm_ack = 1'b0;
            if (force_ack) begin
                dm_ack   = 1'b1;
                dm_rdata = 32'hBAD0BAD0;
                mem_cnt  = 0;
            end else if (dm_req) begin
                if (mem_cnt == 0) begin
                    mem_cap = mk_req(dm_we, dm_addr, dm_wdata);
                    if (req_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_request: got addr=0x%08h we=%0b expected none", dm_addr, dm_we);
                    end else begin
                        mem_e = req_q.pop_front();
                        check("req_we", {31'b0, dm_we}, {31'b0, mem_e.we});
                        check("req_addr", dm_addr, mem_e.addr);
                        check("req_wdata", dm_wdata, mem_e.wdata);
                    end
                end else begin
                    check("req_addr_stable", dm_addr, mem_cap.addr);
                    check("req_we_stable", {31'b0, dm_we}, {31'b0, mem_cap.we});
                    check("req_wdata_stable", dm_wdata, mem_cap.wdata);
                end
                if (mem_cnt == mem_wait) begin
                    dm_ack   = 1'b1;
                    dm_rdata = mem_rdata;
                end
                mem_cnt++;
            end else begin
                mem_cnt = 0;
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Present one instruction, hold it until accepted (stall=0 at the edge), then bubble.
    task automatic issue(input logic mr, input logic mw, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] md, input logic [4:0] rd);
        int k;
        XM_valid = 1'b1; XM_MemRead = mr; XM_MemWrite = mw; XM_RegWrite = rw;
        XM_MemtoReg = m2r; XM_ALUout = alu; XM_MD = md; XM_RD = rd;
        k = 0;
        while (stall && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (stall) check("issue_timeout", {31'b0, stall}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        XM_valid = 1'b0; XM_MemRead = 1'b0; XM_MemWrite = 1'b0; XM_RegWrite = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (stall && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (stall) check("wait_idle_timeout", {31'b0, stall}, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        XM_valid = 1'b0; XM_MemtoReg = 1'b0; XM_RegWrite = 1'b0;
        XM_MemRead = 1'b0; XM_MemWrite = 1'b0;
        XM_ALUout = 32'h0; XM_MD = 32'h0; XM_RD = 5'd0;

        repeat (3) @(negedge clk);
        check("rst_dm_req", {31'b0, dm_req}, 32'h0);
        check("rst_dm_we", {31'b0, dm_we}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_mw_regwrite", {31'b0, MW_RegWrite}, 32'h0);
        check("rst_mw_memtoreg", {31'b0, MW_MemtoReg}, 32'h0);
        check("rst_misalign_err", {31'b0, misalign_err}, 32'h0);
        check("rst_dm_addr", dm_addr, 32'h0);
        check("rst_dm_wdata", dm_wdata, 32'h0);
        check("rst_mw_rd", {27'b0, MW_RD}, 32'h0);
        check("rst_mdr", MDR, 32'h0);
        check("rst_mw_aluout", MW_ALUout, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // add r3 = 7: one-cycle latency, never stalls.
        s0 = stall_total;
        wb_q.push_back(mk_wb(5'd3, 32'h0000_0007, 1'b0, 32'h0, 1'b0, -1));
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0007, 32'h0, 5'd3);
        check("add_visible_next_cycle", {31'b0, MW_RegWrite}, 32'h1);
        @(negedge clk);
        check("add_pulse_one_cycle", {31'b0, MW_RegWrite}, 32'h0);
        check("add_no_stall", stall_total - s0, 32'h0);

        // lw r5 <- [0x40], three wait cycles.
        mem_wait  = 3;
        mem_rdata = 32'hDEADBEEF;
        s0 = stall_total;
        req_q.push_back(mk_req(1'b0, 32'h0000_0040, 32'h0));
        wb_q.push_back(mk_wb(5'd5, 32'h0000_0040, 1'b1, 32'hDEADBEEF, 1'b1, -1));
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 5'd5);
        check("lw_dm_req_high", {31'b0, dm_req}, 32'h1);
        wait_idle();
        check("lw_stall_cycles", stall_total - s0, 32'd4);
        check("lw_retire_visible", {31'b0, MW_RegWrite}, 32'h1);
        check("lw_dm_req_dropped", {31'b0, dm_req}, 32'h0);

        // sw [0x44] <- 0x12345678, zero-wait.
        mem_wait = 0;
        s0 = stall_total;
        req_q.push_back(mk_req(1'b1, 32'h0000_0044, 32'h1234_5678));
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h1234_5678, 5'd0);
        wait_idle();
        check("sw_stall_cycles", stall_total - s0, 32'd1);
        check("sw_no_regwrite", {31'b0, MW_RegWrite}, 32'h0);
        check("sw_mdr_unchanged", MDR, 32'hDEADBEEF);

        // MemRead and MemWrite both set with RegWrite=1: must act as a store.
        mem_rdata = 32'h5555_AAAA;
        req_q.push_back(mk_req(1'b1, 32'h0000_0048, 32'hCAFE_F00D));
        issue(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0048, 32'hCAFE_F00D, 5'd4);
        wait_idle();
        check("both_no_regwrite", {31'b0, MW_RegWrite}, 32'h0);
        check("both_mdr_unchanged", MDR, 32'hDEADBEEF);

        // lw with two wait cycles, add held behind it retires one cycle later.
        mem_wait  = 2;
        mem_rdata = 32'h1111_2222;
        req_q.push_back(mk_req(1'b0, 32'h0000_0080, 32'h0));
        wb_q.push_back(mk_wb(5'd7, 32'h0000_0080, 1'b1, 32'h1111_2222, 1'b1, -1));
        wb_q.push_back(mk_wb(5'd9, 32'h0000_0099, 1'b0, 32'h0, 1'b0, 1));
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'h0, 5'd7);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0099, 32'h0, 5'd9);
        repeat (3) @(negedge clk);

        // Back-to-back zero-wait loads: one idle cycle between requests.
        mem_wait  = 0;
        mem_rdata = 32'hA5A5_0001;
        req_q.push_back(mk_req(1'b0, 32'h0000_0100, 32'h0));
        req_q.push_back(mk_req(1'b0, 32'h0000_0104, 32'h0));
        wb_q.push_back(mk_wb(5'd11, 32'h0000_0100, 1'b1, 32'hA5A5_0001, 1'b1, -1));
        wb_q.push_back(mk_wb(5'd12, 32'h0000_0104, 1'b1, 32'hA5A5_0001, 1'b1, 2));
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd11);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0104, 32'h0, 5'd12);
        wait_idle();
        repeat (2) @(negedge clk);

        // Stray acknowledge with no request outstanding must be ignored.
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        force_ack = 1'b0;
        check("stray_ack_no_stall", {31'b0, stall}, 32'h0);
        check("stray_ack_no_req", {31'b0, dm_req}, 32'h0);

        // Misaligned load to 0x42.
`ifdef MISALIGN_TRAP_EN
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0042, 32'h0, 5'd6);
        check("misalign_no_req", {31'b0, dm_req}, 32'h0);
        check("misalign_no_stall", {31'b0, stall}, 32'h0);
        check("misalign_no_regwrite", {31'b0, MW_RegWrite}, 32'h0);
        check("misalign_err_set", {31'b0, misalign_err}, 32'h1);
        wb_q.push_back(mk_wb(5'd2, 32'h0000_0022, 1'b0, 32'h0, 1'b0, -1));
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0022, 32'h0, 5'd2);
        repeat (3) @(negedge clk);
        check("misalign_err_sticky", {31'b0, misalign_err}, 32'h1);
`else
        mem_rdata = 32'h0BAD_F00D;
        req_q.push_back(mk_req(1'b0, 32'h0000_0042, 32'h0));
        wb_q.push_back(mk_wb(5'd6, 32'h0000_0042, 1'b1, 32'h0BAD_F00D, 1'b1, -1));
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0042, 32'h0, 5'd6);
        check("unaligned_dm_addr", dm_addr, 32'h0000_0042);
        wait_idle();
        check("unaligned_retire", {31'b0, MW_RegWrite}, 32'h1);
        check("misalign_err_tied", {31'b0, misalign_err}, 32'h0);
        repeat (2) @(negedge clk);
`endif

        // Reset while a load is waiting: request abandoned, late ack ignored.
        mem_wait = 1000;
        req_q.push_back(mk_req(1'b0, 32'h0000_0200, 32'h0));
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0, 5'd10);
        @(negedge clk);
        check("pre_reset_stall", {31'b0, stall}, 32'h1);
        check("pre_reset_dm_req", {31'b0, dm_req}, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_dm_req", {31'b0, dm_req}, 32'h0);
        check("midrst_stall", {31'b0, stall}, 32'h0);
        check("midrst_mw_regwrite", {31'b0, MW_RegWrite}, 32'h0);
        check("midrst_misalign_err", {31'b0, misalign_err}, 32'h0);
        check("midrst_dm_addr", dm_addr, 32'h0);
        check("midrst_mdr", MDR, 32'h0);
        rst = 1'b1;
        mem_wait = 0;
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        force_ack = 1'b0;
        check("late_ack_no_regwrite", {31'b0, MW_RegWrite}, 32'h0);
        check("late_ack_no_stall", {31'b0, stall}, 32'h0);

        // Pipeline resumes after reset.
        wb_q.push_back(mk_wb(5'd1, 32'h0000_0031, 1'b0, 32'h0, 1'b0, -1));
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0031, 32'h0, 5'd1);
        repeat (3) @(negedge clk);

        check("wb_queue_drained", wb_q.size(), 32'h0);
        check("req_queue_drained", req_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_writeback.md
# memory_writeback

Memory-access and writeback stage of the 5-stage MIPS pipeline, sitting between the execute stage and instruction decode. It takes the execute-stage result and control bits, performs load/store through a request/acknowledge data-memory port, and drives the register-file write port that instruction decode consumes (MW_RegWrite, MW_RD, MW_MemtoReg, MDR, MW_ALUout). Multi-cycle memory latency is absorbed by a two-state controller that stalls the upstream pipeline.

## Interface
- ADDR_W, 32, width of dm_addr; taken from XM_ALUout[ADDR_W-1:0]
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- XM_valid  in  1  execute-stage slot holds a real instruction
- XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite  in  1 each  execute-stage control bits
- XM_ALUout  in  32  ALU result / effective address
- XM_MD  in  32  store data
- XM_RD  in  5  destination register
- stall  out  1  upstream must hold XM_* unchanged and not advance
- dm_req  out  1  memory request, held until acknowledged
- dm_we  out  1  1 = store, 0 = load
- dm_addr  out  ADDR_W  byte address
- dm_wdata  out  32  store data
- dm_ack  in  1  memory completes the request this cycle
- dm_rdata  in  32  load data, valid when dm_ack=1
- MW_MemtoReg, MW_RegWrite  out  1 each  writeback control to decode
- MW_RD  out  5  writeback register
- MDR  out  32  loaded data
- MW_ALUout  out  32  ALU result passed through
- misalign_err  out  1  sticky misalignment flag

## Operation
- States: IDLE, ACCESS. Reset (rst=0 at an edge): state IDLE; dm_req, dm_we, stall, MW_MemtoReg, MW_RegWrite, misalign_err = 0; dm_addr, dm_wdata, MW_RD, MDR, MW_ALUout = 0.
- stall = (state == ACCESS), decoded from state only; no combinational path from XM_* or dm_ack.
- IDLE, XM_valid=0: next MW_RegWrite=0 (bubble).
- IDLE, XM_valid=1, MemRead=MemWrite=0: next edge loads MW_RegWrite=XM_RegWrite, MW_MemtoReg=0, MW_RD, MW_ALUout; stay IDLE.
- IDLE, XM_valid=1, MemRead or MemWrite: next edge latches dm_addr, dm_wdata=XM_MD, dm_we=XM_MemWrite, saved RD/RegWrite/MemtoReg/ALUout; dm_req=1; state ACCESS; MW_RegWrite=0.
- Both MemRead and MemWrite set: treated as store.
- ACCESS, dm_ack=0: hold all dm_* stable; MW_RegWrite=0.
- ACCESS, dm_ack=1: next edge dm_req=0, state IDLE; load: MDR=dm_rdata, MW_MemtoReg=1, MW_RegWrite=saved RegWrite, MW_RD=saved RD; store: MW_RegWrite=0, MDR unchanged.
- dm_ack ignored when dm_req=0.
- MW_* outputs valid for exactly one cycle per retired instruction; MW_RegWrite returns to 0 unless a new instruction retires.

## Timing
- Non-memory instruction: accepted at edge E0, MW_* visible after E0 (1-cycle latency), stall stays 0.
- Memory instruction accepted at E0; dm_req high after E0; ack sampled at edge Ek (k≥1); MW_* visible after Ek; stall high from after E0 through Ek; next XM instruction accepted at Ek+1. Zero-wait memory (ack in first ACCESS cycle) gives 2-cycle latency, one stall cycle.
- Back-to-back memory ops: one IDLE cycle between consecutive dm_req pulses.
- Reset mid-ACCESS: request abandoned, dm_req=0 after the reset edge; a late dm_ack is ignored; no MW write occurs.

## Configuration
- MISALIGN_TRAP_EN defined: memory op in IDLE with XM_ALUout[1:0]≠0 is not issued; stays IDLE, MW_RegWrite=0 next cycle, misalign_err set and held until reset.
- MISALIGN_TRAP_EN undefined: address issued unchanged regardless of low bits; misalign_err tied 0.

## Test plan
- Reset: rst=0 one edge with ACCESS pending -> all outputs 0, dm_req=0, later dm_ack=1 produces no MW_RegWrite.
- add r3 result 0x0000_0007, RD=3 -> next cycle MW_RegWrite=1, MW_RD=3, MW_ALUout=0x7, MW_MemtoReg=0, stall never 1.
- lw addr 0x40, RD=5, ack after 3 wait cycles with dm_rdata=0xDEADBEEF -> dm_addr=0x40, dm_we=0, stall high 4 cycles, then MDR=0xDEADBEEF, MW_MemtoReg=1, MW_RegWrite=1, MW_RD=5 for one cycle.
- sw addr 0x44, data 0x1234_5678, zero-wait ack -> dm_we=1, dm_wdata=0x12345678, one stall cycle, MW_RegWrite=0.
- lw then add held during stall -> add retires exactly once, one cycle after the lw writeback, XM_* consumed only when stall=0.
- With MISALIGN_TRAP_EN: lw addr 0x42 -> dm_req stays 0, misalign_err=1 sticky, MW_RegWrite=0; without it: dm_addr=0x42 issued, misalign_err=0.
